// File: rtl/counter_check_pkg.sv
// Shared types and default sizing for the counter stream checker.
package counter_check_pkg;

  localparam int unsigned CHK_WIDTH       = 4;
  localparam int unsigned CHK_LOCK_CYCLES = 2;
  localparam int unsigned CHK_CNT_W       = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StTrack
  } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and a build-time choice of saturating or wrapping overflow.
module sat_counter #(
  parameter int unsigned Width    = 8,
  parameter bit          Saturate = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Clear has priority over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (!Saturate || (cnt_q != '1)) begin
        cnt_d = cnt_q + Width'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/counter_checker.sv
// Locks onto an observed counter stream, flags skips/stalls/spurious changes, and counts wraps.
module counter_checker
  import counter_check_pkg::*;
#(
  parameter int unsigned WIDTH       = CHK_WIDTH,
  parameter int unsigned LOCK_CYCLES = CHK_LOCK_CYCLES,
  parameter int unsigned CNT_W       = CHK_CNT_W
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic             sticky_error_o,
  output logic [CNT_W-1:0] error_count_o,
  output logic [CNT_W-1:0] wrap_count_o,
  output logic [WIDTH-1:0] expected_o
);

  localparam logic [3:0] LockCnt = 4'(LOCK_CYCLES);

  chk_state_t       state_q, state_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0] prev_count_q;
  logic             prev_en_q;
  logic [WIDTH-1:0] expected_q;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic             locked_q, locked_d;
  logic             wrap_inc;
  logic [WIDTH-1:0] pred;
  logic             match;

  assign pred  = prev_count_q + WIDTH'(prev_en_q);
  assign match = (count_i == pred);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_d       = 1'b0;
    wrap_inc    = 1'b0;
    unique case (state_q)
      // No valid previous sample yet; just capture one.
      StIdle: state_d = StAcquire;
      StAcquire: begin
        if (match) begin
          if ((match_cnt_q + 4'd1) >= LockCnt) begin
            state_d     = StTrack;
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_cnt_q + 4'd1;
          end
        end else begin
          match_cnt_d = '0;
        end
      end
      StTrack: begin
        if (!match) begin
          err_d       = 1'b1;
          state_d     = StAcquire;
          match_cnt_d = '0;
        end else if ((prev_count_q == '1) && prev_en_q) begin
          wrap_inc = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sticky_d = clear_i ? 1'b0 : (sticky_q | err_d);
  assign locked_d = (state_d == StTrack);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      match_cnt_q  <= '0;
      prev_count_q <= '0;
      prev_en_q    <= 1'b0;
      expected_q   <= '0;
      err_q        <= 1'b0;
      sticky_q     <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      prev_count_q <= count_i;
      prev_en_q    <= enable_i;
      expected_q   <= count_i + WIDTH'(enable_i);
      err_q        <= err_d;
      sticky_q     <= sticky_d;
      locked_q     <= locked_d;
    end
  end

  sat_counter #(
    .Width    (CNT_W),
    .Saturate (1'b1)
  ) u_err_cnt (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clr_i   (clear_i),
    .inc_i   (err_d),
    .count_o (error_count_o)
  );

  sat_counter #(
    .Width    (CNT_W),
    .Saturate (1'b0)
  ) u_wrap_cnt (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clr_i   (clear_i),
    .inc_i   (wrap_inc),
    .count_o (wrap_count_o)
  );

  assign locked_o       = locked_q;
  assign err_pulse_o    = err_q;
  assign sticky_error_o = sticky_q;
  assign expected_o     = expected_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker with a stream-level reference model checked every cycle.
module tb_counter_checker;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic [3:0] count_i;
  logic       enable_i;
  logic       clear_i;
  logic       locked_o;
  logic       err_pulse_o;
  logic       sticky_error_o;
  logic [7:0] error_count_o;
  logic [7:0] wrap_count_o;
  logic [3:0] expected_o;

  int n_cmp  = 0;
  int n_fail = 0;

  counter_checker #(
    .WIDTH       (4),
    .LOCK_CYCLES (2),
    .CNT_W       (8)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .count_i        (count_i),
    .enable_i       (enable_i),
    .clear_i        (clear_i),
    .locked_o       (locked_o),
    .err_pulse_o    (err_pulse_o),
    .sticky_error_o (sticky_error_o),
    .error_count_o  (error_count_o),
    .wrap_count_o   (wrap_count_o),
    .expected_o     (expected_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream is "locked" once two consecutive samples follow
  // the previous value plus its enable; any break while locked is an error.
  bit have_prev = 0;
  int streak    = 0;
  bit m_locked  = 0;
  bit m_err     = 0;
  bit m_sticky  = 0;
  int m_errs    = 0;
  int m_wraps   = 0;
  int m_exp     = 0;
  int m_prev    = 0;
  int m_prev_en = 0;
  bit ok;

  initial forever begin
    @(posedge clock_i or posedge reset_i);
    if (reset_i) begin
      have_prev = 0; streak = 0; m_locked = 0; m_err = 0; m_sticky = 0;
      m_errs = 0; m_wraps = 0; m_exp = 0; m_prev = 0; m_prev_en = 0;
    end else begin
      ok    = (int'(count_i) == (m_prev + m_prev_en) % 16);
      m_err = 0;
      if (!have_prev) begin
        have_prev = 1;
      end else if (m_locked) begin
        if (!ok) begin
          m_err = 1; m_sticky = 1; m_locked = 0; streak = 0;
          if (m_errs < 255) m_errs++;
        end else if (m_prev == 15 && m_prev_en == 1) begin
          m_wraps = (m_wraps + 1) % 256;
        end
      end else if (ok) begin
        streak++;
        if (streak >= 2) begin
          m_locked = 1;
          streak   = 0;
        end
      end else begin
        streak = 0;
      end
      if (clear_i) begin
        m_sticky = 0; m_errs = 0; m_wraps = 0;
      end
      m_exp     = (int'(count_i) + int'(enable_i)) % 16;
      m_prev    = int'(count_i);
      m_prev_en = int'(enable_i);
    end
  end

  initial forever begin
    @(negedge clock_i);
    if (!reset_i) begin
      check("model locked", 32'(locked_o), 32'(m_locked));
      check("model err_pulse", 32'(err_pulse_o), 32'(m_err));
      check("model sticky", 32'(sticky_error_o), 32'(m_sticky));
      check("model error_count", 32'(error_count_o), 32'(m_errs));
      check("model wrap_count", 32'(wrap_count_o), 32'(m_wraps));
      check("model expected", 32'(expected_o), 32'(m_exp));
    end
  end

  task automatic step(input int c, input bit e, input bit cl);
    count_i  = 4'(c);
    enable_i = e;
    clear_i  = cl;
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " locked"}, 32'(locked_o), 0);
    check({tag, " err_pulse"}, 32'(err_pulse_o), 0);
    check({tag, " sticky"}, 32'(sticky_error_o), 0);
    check({tag, " error_count"}, 32'(error_count_o), 0);
    check({tag, " wrap_count"}, 32'(wrap_count_o), 0);
    check({tag, " expected"}, 32'(expected_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  int cur;

  initial begin
    reset_i  = 1'b1;
    count_i  = '0;
    enable_i = 1'b0;
    clear_i  = 1'b0;
    repeat (2) @(negedge clock_i);
    check_all_zero("reset");
    reset_i = 1'b0;

    // Static stream locks after edge 3.
    step(0, 0, 0); check("lock edge1", 32'(locked_o), 0);
    step(0, 0, 0); check("lock edge2", 32'(locked_o), 0);
    step(0, 0, 0); check("lock edge3", 32'(locked_o), 1);
    check("static expected", 32'(expected_o), 0);
    check("static error_count", 32'(error_count_o), 0);

    // Free run through one 15->0 wrap.
    for (int v = 0; v < 16; v++) step(v, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    check("freerun wrap_count", 32'(wrap_count_o), 1);
    check("freerun expected", 32'(expected_o), 2);
    check("freerun locked", 32'(locked_o), 1);

    // Skip 5 -> 7.
    for (int v = 2; v <= 5; v++) step(v, 1, 0);
    step(7, 1, 0);
    check("skip err_pulse", 32'(err_pulse_o), 1);
    check("skip error_count", 32'(error_count_o), 1);
    check("skip sticky", 32'(sticky_error_o), 1);
    check("skip locked", 32'(locked_o), 0);
    step(8, 1, 0);
    check("skip pulse width", 32'(err_pulse_o), 0);
    check("relock after 1", 32'(locked_o), 0);
    step(9, 0, 0);
    check("relock after 2", 32'(locked_o), 1);

    // Hold with enable low is fine; change with enable low is not.
    step(9, 0, 0);
    check("hold no err", 32'(err_pulse_o), 0);
    check("hold locked", 32'(locked_o), 1);
    step(10, 0, 0);
    check("spurious err_pulse", 32'(err_pulse_o), 1);
    check("spurious error_count", 32'(error_count_o), 2);

    // 300 errors, each after a re-lock on a held value.
    cur = 10;
    for (int i = 0; i < 300; i++) begin
      step(cur, 0, 0);
      step(cur, 0, 0);
      cur = cur ^ 1;
      step(cur, 0, 0);
    end
    check("sat error_count", 32'(error_count_o), 255);
    check("sat sticky", 32'(sticky_error_o), 1);
    step(cur, 0, 0);
    step(cur, 0, 0);
    check("sat held", 32'(error_count_o), 255);
    check("sat relocked", 32'(locked_o), 1);
    cur = cur ^ 1;
    step(cur, 0, 1);
    check("clear err_pulse", 32'(err_pulse_o), 1);
    check("clear error_count", 32'(error_count_o), 0);
    check("clear sticky", 32'(sticky_error_o), 0);
    check("clear wrap_count", 32'(wrap_count_o), 0);

    // Lock on 12, then reset asynchronously between edges.
    step(12, 0, 0);
    step(12, 0, 0);
    step(12, 0, 0);
    check("pre-reset locked", 32'(locked_o), 1);
    check("pre-reset expected", 32'(expected_o), 12);
    #2 reset_i = 1'b1;
    #1 check_all_zero("async reset");
    @(negedge clock_i);
    reset_i = 1'b0;
    step(12, 0, 0); check("re-lock edge1", 32'(locked_o), 0);
    step(12, 0, 0); check("re-lock edge2", 32'(locked_o), 0);
    step(12, 0, 0); check("re-lock edge3", 32'(locked_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
